rbcp_guard: RTL and testbench
=============================

Name: rbcp_guard

Overview:
- Request sequencer and watchdog between the SiTCP RBCP master port and the RBCP register file (addr/we/wd/re/rd/ack/act interface).
- Registers one RBCP transaction and forwards it downstream as a single-cycle strobe.
- Returns exactly one ACK upstream per request: the downstream ACK, or a synthesized timeout ACK carrying a marker byte if the downstream never answers, so the SiTCP client never hangs.

Parameters:
- TIMEOUT_CYC, 1024: cycles in WAIT before a timeout ACK is synthesized; legal 2..65535.
- TIMEOUT_DATA, 8'hEE: read data returned on timeout.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- S_ACT  in  1  upstream active
- S_ADDR  in  32  upstream address
- S_WE  in  1  upstream write strobe (1-cycle pulse)
- S_WD  in  8  upstream write data
- S_RE  in  1  upstream read strobe (1-cycle pulse)
- S_RD  out  8  upstream read data, valid with S_ACK
- S_ACK  out  1  upstream acknowledge (1-cycle pulse)
- M_ACT  out  1  downstream active
- M_ADDR  out  32  downstream address (latched)
- M_WE  out  1  downstream write strobe
- M_WD  out  8  downstream write data (latched)
- M_RE  out  1  downstream read strobe
- M_RD  in  8  downstream read data
- M_ACK  in  1  downstream acknowledge
- BUSY  out  1  high in every state except IDLE
- TIMEOUT_CNT  out  16  saturating timeout count
- DROP_CNT  out  16  saturating count of ignored requests

Behaviour:
- Clock and reset (already decided): one clock, CLK. Reset RST is asynchronous and active-high. All outputs and state reset to 0; FSM resets to IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - On S_ACT=1 and (S_WE|S_RE)=1: latch S_ADDR, S_WD and the request type, then go to ISSUE.
  - If S_WE and S_RE are both 1: treat as a write.
  - Strobe with S_ACT=0: ignored, not counted.
  - Stray M_ACK: ignored.
- ISSUE (1 cycle):
  - M_WE or M_RE = 1 according to the latched type; M_ACT=1.
  - M_ADDR/M_WD hold the latched values from ISSUE through RESP.
  - Next state: WAIT; timeout counter cleared to 0.
  - An M_ACK sampled in ISSUE is accepted as in WAIT.
- WAIT:
  - M_ACT=1; the counter increments every cycle.
  - M_ACK=1: capture M_RD into the response register, go to RESP.
  - Otherwise, counter == TIMEOUT_CYC-1: response = TIMEOUT_DATA, TIMEOUT_CNT +1 (saturating at 16'hFFFF), go to RESP.
  - M_ACK on the final cycle, simultaneous with the timeout: the ACK wins and no timeout is counted.
- RESP (1 cycle): S_ACK=1, S_RD = response register, M_ACT=0. Next state: IDLE.
  - S_RD is 0 whenever S_ACK=0.
  - Writes return the captured M_RD value.
- Late M_ACK (arriving after a timeout) in IDLE: dropped, no upstream effect.
- Request (S_WE|S_RE with S_ACT=1) while BUSY: ignored, DROP_CNT +1 (saturating).
- Abort: S_ACT falling to 0 in ISSUE or WAIT → IDLE next cycle, no S_ACK, M_ACT=0, no counter change.
- Latency: strobe sampled at cycle t gives M_WE/M_RE at t+1. M_ACK sampled at cycle u gives S_ACK at u+1. Timeout gives S_ACK at t+TIMEOUT_CYC+2.
- Reset mid-transaction: immediate return to IDLE, all strobes 0, counters 0.

Optional Feature:
- Macro RBCP_GUARD_STAT_EN.
- Defined: TIMEOUT_CNT and DROP_CNT are implemented as described.
- Undefined: both ports are tied to 16'h0, their counter registers are not built, and FSM/timeout behaviour is otherwise identical.

Test Plan:
- Read, prompt ACK: S_RE at addr 32'h0000_0010; downstream acks 3 cycles after M_RE with M_RD=8'h5A → M_RE 1 cycle after S_RE, M_ADDR=32'h0000_0010, S_ACK 1 cycle after M_ACK, S_RD=8'h5A, exactly one S_ACK.
- Timeout: TIMEOUT_CYC=16; S_WE, S_WD=8'h3C, no M_ACK → M_WD=8'h3C; S_ACK at t+18, S_RD=8'hEE; TIMEOUT_CNT=1.
- Late ACK: same as the timeout case, then M_ACK 5 cycles after the timeout S_ACK → no extra S_ACK; the next read completes normally.
- Busy request: second S_RE while in WAIT → ignored; only the first transaction gets an S_ACK; DROP_CNT=1 (0 with RBCP_GUARD_STAT_EN undefined).
- Boundary: M_ACK on WAIT cycle TIMEOUT_CYC-1 with M_RD=8'h11 → S_RD=8'h11, TIMEOUT_CNT unchanged. Abort: S_ACT dropped in WAIT → no S_ACK, M_ACT=0, BUSY=0 next cycle.
- Reset: RST asserted asynchronously mid-WAIT → all outputs 0 immediately, FSM in IDLE; a fresh read after release completes.

Source files
------------

// File: rtl/rbcp_guard.sv
// rbcp_guard: sequences one SiTCP RBCP transaction at a time toward the
// register file. It guarantees exactly one upstream ACK per request: either
// the downstream ACK, or a synthesized timeout ACK carrying TIMEOUT_DATA.
// The build macro RBCP_GUARD_STAT_EN adds the saturating TIMEOUT_CNT and
// DROP_CNT counters. Without it, both ports read as zero.
module rbcp_guard #(
  parameter int unsigned TIMEOUT_CYC  = 1024,
  parameter logic [7:0]  TIMEOUT_DATA = 8'hEE
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        S_ACT,
  input  logic [31:0] S_ADDR,
  input  logic        S_WE,
  input  logic [7:0]  S_WD,
  input  logic        S_RE,
  output logic [7:0]  S_RD,
  output logic        S_ACK,
  output logic        M_ACT,
  output logic [31:0] M_ADDR,
  output logic        M_WE,
  output logic [7:0]  M_WD,
  output logic        M_RE,
  input  logic [7:0]  M_RD,
  input  logic        M_ACK,
  output logic        BUSY,
  output logic [15:0] TIMEOUT_CNT,
  output logic [15:0] DROP_CNT
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        is_wr, is_wr_nxt;
  logic [7:0]  resp, resp_nxt;
  logic [31:0] addr_nxt;
  logic [7:0]  wd_nxt;
  logic        act_nxt, we_nxt, re_nxt, ack_nxt, busy_nxt;
  logic [7:0]  rd_nxt;
  logic        req;

  assign req = S_ACT & (S_WE | S_RE);

  // Next-state logic and next values for every registered output.
  // An abort (S_ACT low) takes priority over a same-cycle M_ACK.
  // An M_ACK takes priority over the timeout on the last WAIT cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    is_wr_nxt = is_wr;
    resp_nxt  = resp;
    addr_nxt  = M_ADDR;
    wd_nxt    = M_WD;
    unique case (state)
      IDLE: if (req) begin
        addr_nxt  = S_ADDR;
        wd_nxt    = S_WD;
        is_wr_nxt = S_WE;          // WE together with RE is treated as a write
        state_nxt = ISSUE;
      end
      ISSUE: begin
        cnt_nxt = 16'd0;
        if (!S_ACT)     state_nxt = IDLE;
        else if (M_ACK) begin resp_nxt = M_RD; state_nxt = RESP; end
        else            state_nxt = WAIT;
      end
      WAIT: begin
        if (!S_ACT)     state_nxt = IDLE;
        else if (M_ACK) begin resp_nxt = M_RD; state_nxt = RESP; end
        else if (cnt == TO_LAST) begin
          resp_nxt  = TIMEOUT_DATA;
          state_nxt = RESP;
        end
        else cnt_nxt = cnt + 16'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    act_nxt  = (state_nxt == ISSUE) || (state_nxt == WAIT);
    we_nxt   = (state_nxt == ISSUE) &&  is_wr_nxt;
    re_nxt   = (state_nxt == ISSUE) && !is_wr_nxt;
    ack_nxt  = (state_nxt == RESP);
    rd_nxt   = ack_nxt ? resp_nxt : 8'h00;
    busy_nxt = (state_nxt != IDLE);
  end

  // State register and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= 16'd0;
      is_wr  <= 1'b0;
      resp   <= 8'h00;
      M_ADDR <= 32'h0;
      M_WD   <= 8'h00;
      M_ACT  <= 1'b0;
      M_WE   <= 1'b0;
      M_RE   <= 1'b0;
      S_ACK  <= 1'b0;
      S_RD   <= 8'h00;
      BUSY   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      is_wr  <= is_wr_nxt;
      resp   <= resp_nxt;
      M_ADDR <= addr_nxt;
      M_WD   <= wd_nxt;
      M_ACT  <= act_nxt;
      M_WE   <= we_nxt;
      M_RE   <= re_nxt;
      S_ACK  <= ack_nxt;
      S_RD   <= rd_nxt;
      BUSY   <= busy_nxt;
    end
  end

`ifdef RBCP_GUARD_STAT_EN
  logic to_hit, drop_hit;
  logic [15:0] to_q, drop_q;

  assign to_hit   = (state == WAIT) & S_ACT & ~M_ACK & (cnt == TO_LAST);
  assign drop_hit = req & (state != IDLE);

  // Saturating statistics counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      to_q   <= 16'd0;
      drop_q <= 16'd0;
    end else begin
      if (to_hit   && to_q   != 16'hFFFF) to_q   <= to_q + 16'd1;
      if (drop_hit && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  assign TIMEOUT_CNT = to_q;
  assign DROP_CNT    = drop_q;
`else
  assign TIMEOUT_CNT = 16'h0;
  assign DROP_CNT    = 16'h0;
`endif

endmodule

// File: tb/tb_rbcp_guard.sv
// Directed bench for rbcp_guard. A queue holds the expected S_RD for each
// S_ACK; a negedge monitor pops the queue and checks the value.
module tb_rbcp_guard;
  localparam int TC = 16;
`ifdef RBCP_GUARD_STAT_EN
  localparam int STAT = 1;
`else
  localparam int STAT = 0;
`endif

  logic        CLK = 1'b0, RST = 1'b1;
  logic        S_ACT = 0, S_WE = 0, S_RE = 0, M_ACK = 0;
  logic [31:0] S_ADDR = '0;
  logic [7:0]  S_WD = '0, M_RD = '0;
  logic [7:0]  S_RD, M_WD;
  logic        S_ACK, M_ACT, M_WE, M_RE, BUSY;
  logic [31:0] M_ADDR;
  logic [15:0] TIMEOUT_CNT, DROP_CNT;

  int total = 0, bad = 0, ack_cnt = 0;
  int exp_to = 0, exp_drop = 0, exp_acks = 0;
  logic [7:0] exp_q[$];

  rbcp_guard #(.TIMEOUT_CYC(TC), .TIMEOUT_DATA(8'hEE)) dut (
    .CLK(CLK), .RST(RST), .S_ACT(S_ACT), .S_ADDR(S_ADDR), .S_WE(S_WE),
    .S_WD(S_WD), .S_RE(S_RE), .S_RD(S_RD), .S_ACK(S_ACK), .M_ACT(M_ACT),
    .M_ADDR(M_ADDR), .M_WE(M_WE), .M_WD(M_WD), .M_RE(M_RE), .M_RD(M_RD),
    .M_ACK(M_ACK), .BUSY(BUSY), .TIMEOUT_CNT(TIMEOUT_CNT), .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin @(posedge CLK); #1; end
  endtask

  // Scoreboard monitor: each S_ACK consumes one expected value.
  // S_RD must read zero whenever S_ACK is low.
  always @(negedge CLK) begin
    if (!RST) begin
      if (S_ACK) begin
        ack_cnt++;
        if (exp_q.size() == 0) chk("unexpected_ack", {31'b0, S_ACK}, 32'd0);
        else chk("s_rd", {24'b0, S_RD}, {24'b0, exp_q.pop_front()});
      end else begin
        chk("s_rd_idle", {24'b0, S_RD}, 32'd0);
      end
    end
  end

  initial begin
    // Reset state
    #12;
    chk("rst_busy", {31'b0, BUSY}, 0);
    chk("rst_mact", {31'b0, M_ACT}, 0);
    chk("rst_sack", {31'b0, S_ACK}, 0);
    chk("rst_maddr", M_ADDR, 0);
    @(posedge CLK); #1 RST = 0;

    // Read with a prompt ACK
    S_ACT = 1; S_RE = 1; S_ADDR = 32'h10; exp_q.push_back(8'h5A); exp_acks++;
    tick();
    S_RE = 0;
    chk("rd_mre", {31'b0, M_RE}, 1);
    chk("rd_mwe", {31'b0, M_WE}, 0);
    chk("rd_mact", {31'b0, M_ACT}, 1);
    chk("rd_maddr", M_ADDR, 32'h10);
    chk("rd_busy", {31'b0, BUSY}, 1);
    tick();
    chk("rd_mre_pulse", {31'b0, M_RE}, 0);
    tick(2);
    M_ACK = 1; M_RD = 8'h5A;
    tick();
    M_ACK = 0;
    chk("rd_sack", {31'b0, S_ACK}, 1);
    chk("rd_srd", {24'b0, S_RD}, 32'h5A);
    chk("rd_mact_resp", {31'b0, M_ACT}, 0);
    tick();
    chk("rd_sack_pulse", {31'b0, S_ACK}, 0);
    chk("rd_idle", {31'b0, BUSY}, 0);
    S_ACT = 0;
    tick();
    chk("rd_acks", ack_cnt, exp_acks);

    // Write that times out
    S_ACT = 1; S_WE = 1; S_WD = 8'h3C; S_ADDR = 32'h20; exp_q.push_back(8'hEE); exp_acks++;
    tick();
    S_WE = 0;
    chk("to_mwe", {31'b0, M_WE}, 1);
    chk("to_mwd", {24'b0, M_WD}, 32'h3C);
    tick(TC);
    chk("to_no_early_ack", {31'b0, S_ACK}, 0);
    tick();
    chk("to_sack", {31'b0, S_ACK}, 1);
    chk("to_srd", {24'b0, S_RD}, 32'hEE);
    chk("to_mwd_hold", {24'b0, M_WD}, 32'h3C);
    exp_to += STAT;
    S_ACT = 0;
    tick();
    chk("to_cnt", TIMEOUT_CNT, exp_to);

    // A late ACK after the timeout is dropped
    tick(4);
    M_ACK = 1; M_RD = 8'hBB;
    tick();
    M_ACK = 0;
    tick(2);
    chk("late_acks", ack_cnt, exp_acks);
    chk("late_busy", {31'b0, BUSY}, 0);
    // The next read completes normally
    S_ACT = 1; S_RE = 1; S_ADDR = 32'h30; exp_q.push_back(8'h77); exp_acks++;
    tick();
    S_RE = 0;
    tick();
    M_ACK = 1; M_RD = 8'h77;
    tick();
    M_ACK = 0;
    chk("late_next_sack", {31'b0, S_ACK}, 1);
    S_ACT = 0;
    tick(2);
    chk("late_next_acks", ack_cnt, exp_acks);

    // A request while busy is dropped
    S_ACT = 1; S_RE = 1; S_ADDR = 32'h40; exp_q.push_back(8'h99); exp_acks++;
    tick();
    S_RE = 0;
    tick();
    S_RE = 1; S_ADDR = 32'h44;
    tick();
    S_RE = 0;
    exp_drop += STAT;
    chk("busy_maddr", M_ADDR, 32'h40);
    chk("busy_mre", {31'b0, M_RE}, 0);
    M_ACK = 1; M_RD = 8'h99;
    tick();
    M_ACK = 0;
    S_ACT = 0;
    tick(3);
    chk("busy_acks", ack_cnt, exp_acks);
    chk("busy_drop", DROP_CNT, exp_drop);
    chk("busy_idle", {31'b0, BUSY}, 0);

    // A strobe with S_ACT low is ignored and not counted
    S_RE = 1;
    tick();
    S_RE = 0;
    chk("noact_busy", {31'b0, BUSY}, 0);
    chk("noact_mre", {31'b0, M_RE}, 0);
    chk("noact_drop", DROP_CNT, exp_drop);

    // WE and RE together: treated as a write, which returns M_RD
    S_ACT = 1; S_WE = 1; S_RE = 1; S_WD = 8'h12; S_ADDR = 32'h48;
    exp_q.push_back(8'h42); exp_acks++;
    tick();
    S_WE = 0; S_RE = 0;
    chk("both_mwe", {31'b0, M_WE}, 1);
    chk("both_mre", {31'b0, M_RE}, 0);
    M_ACK = 1; M_RD = 8'h42;
    tick();
    M_ACK = 0;
    chk("both_sack", {31'b0, S_ACK}, 1);
    S_ACT = 0;
    tick(2);

    // An ACK on the final WAIT cycle beats the timeout
    S_ACT = 1; S_WE = 1; S_WD = 8'h55; S_ADDR = 32'h4C; exp_q.push_back(8'h11); exp_acks++;
    tick();
    S_WE = 0;
    tick(TC);
    M_ACK = 1; M_RD = 8'h11;
    tick();
    M_ACK = 0;
    chk("bnd_sack", {31'b0, S_ACK}, 1);
    chk("bnd_srd", {24'b0, S_RD}, 32'h11);
    S_ACT = 0;
    tick();
    chk("bnd_to_cnt", TIMEOUT_CNT, exp_to);

    // Abort: S_ACT drops during WAIT
    S_ACT = 1; S_RE = 1; S_ADDR = 32'h50;
    tick();
    S_RE = 0;
    tick(2);
    S_ACT = 0;
    tick();
    chk("abort_mact", {31'b0, M_ACT}, 0);
    chk("abort_busy", {31'b0, BUSY}, 0);
    chk("abort_sack", {31'b0, S_ACK}, 0);
    tick(TC + 4);
    chk("abort_acks", ack_cnt, exp_acks);
    chk("abort_to_cnt", TIMEOUT_CNT, exp_to);

    // Asynchronous reset in the middle of WAIT
    S_ACT = 1; S_RE = 1; S_ADDR = 32'h60;
    tick();
    S_RE = 0;
    tick(2);
    #2 RST = 1;
    #1;
    exp_to = 0; exp_drop = 0;
    chk("arst_mact", {31'b0, M_ACT}, 0);
    chk("arst_busy", {31'b0, BUSY}, 0);
    chk("arst_maddr", M_ADDR, 0);
    chk("arst_to_cnt", TIMEOUT_CNT, 0);
    chk("arst_drop", DROP_CNT, 0);
    S_ACT = 0;
    @(posedge CLK); #1 RST = 0;
    tick();
    S_ACT = 1; S_RE = 1; S_ADDR = 32'h70; exp_q.push_back(8'hA5); exp_acks++;
    tick();
    S_RE = 0;
    chk("post_maddr", M_ADDR, 32'h70);
    tick();
    M_ACK = 1; M_RD = 8'hA5;
    tick();
    M_ACK = 0;
    chk("post_sack", {31'b0, S_ACK}, 1);
    S_ACT = 0;
    tick(2);
    chk("final_acks", ack_cnt, exp_acks);
    chk("q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
